// File: rtl/nibble_deser4x4_if.sv
// Nibble deserializer link bundle: nibble input handshake, word output
// handshake and the status outputs (framing error pulse, next slot index).
interface nibble_deser4x4_if #(
    parameter int NIBBLES = 4
);
    localparam int SLOT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int WORD_W = 4 * NIBBLES;

    logic [3:0]        in_nibble;
    logic              in_valid;
    logic              in_first;
    logic              in_ready;
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;
    logic              frame_err;
    logic [SLOT_W-1:0] slot;

    // Producer of nibbles / consumer of words.
    modport master (
        output in_nibble, in_valid, in_first, out_ready,
        input  in_ready, out_word, out_valid, frame_err, slot
    );

    // The deserializer itself.
    modport slave (
        input  in_nibble, in_valid, in_first, out_ready,
        output in_ready, out_word, out_valid, frame_err, slot
    );
endinterface

// File: rtl/nibble_deser4x4.sv
// Nibble deserializer: collects NIBBLES 4-bit nibbles (slot 0 = bits [3:0])
// into a word and presents it on a registered valid/ready output. A nibble
// flagged in_first while mid-word discards the partial word and restarts it.
module nibble_deser4x4 #(
    parameter int NIBBLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    nibble_deser4x4_if.slave  bus
);
    localparam int SLOT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int WORD_W = 4 * NIBBLES;
    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NIBBLES - 1);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;

    logic              in_ready_c;
    logic              accept;
    logic [SLOT_W-1:0] fill;

    // Next-state: handshake decode, nibble placement, word hand-off to output.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        slot_d  = slot_q;
        asm_d   = asm_q;
        word_d  = word_q;
        valid_d = valid_q && !bus.out_ready;
        ferr_d  = 1'b0;
        fill    = slot_q;

        // Stall only the final nibble, and only when the output cannot drain
        // this cycle; a simultaneous drain and load keeps full rate.
        in_ready_c = !((slot_q == LAST) && valid_q && !bus.out_ready);
        accept     = bus.in_valid && in_ready_c;

        if (accept) begin
            // in_first mid-word: drop the partial word and restart at slot 0.
            ferr_d = bus.in_first && (slot_q != '0);
            fill   = ferr_d ? '0 : slot_q;

            asm_d[{fill, 2'b00} +: 4] = bus.in_nibble;

            if (fill == LAST) begin
                word_d  = asm_d;
                valid_d = 1'b1;
                slot_d  = '0;
            end else begin
                slot_d = fill + SLOT_W'(1);
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from the pre-edge values.
        if (!reset_n) begin
            slot_q  <= '0;
            asm_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            asm_q   <= asm_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_word  = word_q;
    assign bus.out_valid = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.slot      = slot_q;

endmodule

// File: tb/tb_nibble_deser4x4.sv
// Directed bench for nibble_deser4x4: expected words go into a scoreboard
// queue as their last nibble is driven and are popped on each output transfer.
module tb_nibble_deser4x4;
    localparam int NIBBLES = 4;

    logic clk = 1'b0;
    logic reset_n;

    nibble_deser4x4_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_deser4x4 #(.NIBBLES(NIBBLES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] sb[$];
    bit          ferr_exp = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge. Inputs are driven,
    // then in_ready / frame_err / output transfer are sampled mid-cycle.
    task automatic cyc(input bit v, input logic [3:0] nib, input bit first,
                       input bit ordy, input bit rdy_exp);
        logic [15:0] exp_word;
        bus.in_valid  = v;
        bus.in_nibble = nib;
        bus.in_first  = first;
        bus.out_ready = ordy;
        #1;
        check("in_ready", 64'(bus.in_ready), 64'(rdy_exp));
        check("frame_err", 64'(bus.frame_err), 64'(ferr_exp));
        ferr_exp = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 64'(sb.size()), 64'd1);
            end else begin
                exp_word = sb.pop_front();
                check("out_word", 64'(bus.out_word), 64'(exp_word));
            end
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w, input bit first, input bit ordy);
        for (int k = 0; k < NIBBLES; k++) begin
            if (k == NIBBLES - 1) sb.push_back(w);
            cyc(1'b1, w[4*k +: 4], first && (k == 0), ordy, 1'b1);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_nibble = 4'h0;
        bus.in_first  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_word", 64'(bus.out_word), 64'd0);
        check("rst_frame_err", 64'(bus.frame_err), 64'd0);
        check("rst_slot", 64'(bus.slot), 64'd0);
        reset_n = 1'b1;

        // Single word 0x1234, one-cycle latency.
        cyc(1'b1, 4'h4, 1'b1, 1'b1, 1'b1);
        check("t1_slot1", 64'(bus.slot), 64'd1);
        cyc(1'b1, 4'h3, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 4'h2, 1'b0, 1'b1, 1'b1);
        check("t1_valid_early", 64'(bus.out_valid), 64'd0);
        sb.push_back(16'h1234);
        cyc(1'b1, 4'h1, 1'b0, 1'b1, 1'b1);
        check("t1_valid", 64'(bus.out_valid), 64'd1);
        check("t1_word", 64'(bus.out_word), 64'h1234);
        check("t1_slot0", 64'(bus.slot), 64'd0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        check("t1_drained", 64'(bus.out_valid), 64'd0);

        // Back-to-back words, no bubbles.
        send_word(16'h1234, 1'b1, 1'b1);
        check("t2_word_a", 64'(bus.out_word), 64'h1234);
        send_word(16'hBEEF, 1'b1, 1'b1);
        check("t2_valid_b", 64'(bus.out_valid), 64'd1);
        check("t2_word_b", 64'(bus.out_word), 64'hBEEF);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);

        // Backpressure: final nibble stalls until the output drains.
        send_word(16'h1234, 1'b1, 1'b0);
        cyc(1'b1, 4'hF, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
        check("t3_slot3", 64'(bus.slot), 64'd3);
        cyc(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
        check("t3_hold_slot", 64'(bus.slot), 64'd3);
        check("t3_hold_valid", 64'(bus.out_valid), 64'd1);
        check("t3_hold_word", 64'(bus.out_word), 64'h1234);
        sb.push_back(16'hBEEF);
        cyc(1'b1, 4'hB, 1'b0, 1'b1, 1'b1);
        check("t3_valid", 64'(bus.out_valid), 64'd1);
        check("t3_word", 64'(bus.out_word), 64'hBEEF);
        check("t3_slot0", 64'(bus.slot), 64'd0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        check("t3_drained", 64'(bus.out_valid), 64'd0);

        // Misalignment: in_first mid-word drops 0xA/0xB and pulses frame_err.
        cyc(1'b1, 4'hA, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 4'hB, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 4'h5, 1'b1, 1'b1, 1'b1);
        check("t4_slot1", 64'(bus.slot), 64'd1);
        ferr_exp = 1'b1;
        cyc(1'b1, 4'h6, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
        sb.push_back(16'h8765);
        cyc(1'b1, 4'h8, 1'b0, 1'b1, 1'b1);
        check("t4_word", 64'(bus.out_word), 64'h8765);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);

        // Reset mid-word with a pending output word.
        send_word(16'h1234, 1'b1, 1'b0);
        cyc(1'b1, 4'h5, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
        check("t5_slot2", 64'(bus.slot), 64'd2);
        check("t5_pending", 64'(bus.out_valid), 64'd1);
        reset_n = 1'b0;
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b1;
        sb.delete();
        check("t5_valid", 64'(bus.out_valid), 64'd0);
        check("t5_slot", 64'(bus.slot), 64'd0);
        check("t5_word", 64'(bus.out_word), 64'd0);
        send_word(16'h0F0F, 1'b0, 1'b1);
        check("t5_new_word", 64'(bus.out_word), 64'h0F0F);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);

        // Gapped input, output held across idle cycles.
        cyc(1'b1, 4'hC, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'hA, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        check("t6_slot3", 64'(bus.slot), 64'd3);
        sb.push_back(16'hEFAC);
        cyc(1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t6_hold_valid", 64'(bus.out_valid), 64'd1);
            check("t6_hold_word", 64'(bus.out_word), 64'hEFAC);
            cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        check("t6_drained", 64'(bus.out_valid), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_deser4x4.md
Name: nibble_deser4x4

Overview:
- Receive-side counterpart of the nibble serializer, which uses a 4:1 four-bit mux with sel stepping 0..3.
- Accepts a stream of 4-bit nibbles over a valid/ready handshake and reassembles them into NIBBLES×4-bit words (16b default, one half-precision operand).
- Presents each word on a registered valid/ready output port.
- Sits between the nibble-wide operand link and the FP datapath input registers.

Parameters:
- NIBBLES, 4, nibbles per word. Legal range 2..8. Output width is 4*NIBBLES.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low.
- in_nibble  input  4  nibble data.
- in_valid  input  1  in_nibble valid this cycle.
- in_first  input  1  qualifies in_nibble as the first nibble (slot 0) of a word.
- in_ready  output  1  block accepts in_nibble this cycle.
- out_word  output  4*NIBBLES  assembled word.
- out_valid  output  1  out_word holds a complete word.
- out_ready  input  1  consumer accepts out_word.
- frame_err  output  1  one-cycle pulse: a partial word was discarded.
- slot  output  2 (for NIBBLES≤4; clog2(NIBBLES) generally)  index of the next nibble slot to fill.

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: in_ready=1, out_valid=0, out_word=0, frame_err=0, slot=0, assembly register=0.
- Accept/deliver conditions:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Slot ordering: matches the serializer mux select.
  - Nibble accepted at slot k is written to assembly bits [4k+3:4k].
  - Slot 0 = bits[3:0], i.e. the sel=00 input.
- States (slot counter plus output-full flag):
  - COLLECT: slot 0..NIBBLES-1.
  - Output register FULL or EMPTY, tracked independently.
- Transitions on accept:
  - slot < NIBBLES-1: write nibble, slot increments.
  - slot = NIBBLES-1: the word (assembly register plus this nibble) is copied to out_word next edge, out_valid=1, slot wraps to 0.
- in_ready:
  - 0 only when slot = NIBBLES-1 and out_valid=1 and out_ready=0.
  - Otherwise 1, including the final nibble arriving in the same cycle as an output transfer (simultaneous drain and load; no bubble).
- Throughput and latency:
  - Throughput is one nibble per cycle, sustained with out_ready held high.
  - Latency is one cycle: out_valid rises the edge after the last nibble is accepted.
- in_first alignment:
  - Accepted with in_first=1 while slot≠0: partial word dropped, frame_err pulses for one cycle, nibble written to slot 0, slot=1.
  - in_first=1 at slot 0: normal.
  - in_first=0 at slot 0: accepted as slot 0; no error.
- Output hold: out_word and out_valid hold stable while out_valid=1 and out_ready=0. out_valid drops after a transfer unless a new word loads on the same edge.
- in_valid=0: no state change; the assembly register holds.
- Assembly register: not cleared between words; stale bits are fully overwritten before delivery.
- Reset mid-word: partial word discarded, pending out_word discarded, all outputs return to reset values on that edge.
- frame_err on reset: never asserted by reset itself.
- X handling: no X driven on any output after reset.

Test Plan:
- Reset then nibbles 0x4,0x3,0x2,0x1 on consecutive cycles (first flagged), out_ready=1 -> out_valid one cycle after the 4th nibble, out_word=16'h1234, slot back to 0.
- Back-to-back words 0x1234 then 0xBEEF streamed with no gaps, out_ready=1 -> in_ready constant 1; out_word 16'h1234 then 16'hBEEF on consecutive word boundaries; no bubbles.
- Backpressure: out_ready=0 while 0x1234 waits and the next word's first 3 nibbles arrive -> those 3 accepted, in_ready=0 at slot 3. out_ready=1 for one cycle -> 4th nibble accepted in that cycle, next word 0xBEEF appears the following edge.
- Misalignment: nibbles 0xA,0xB accepted, then 0x5 with in_first=1, followed by 0x6,0x7,0x8 -> frame_err pulses exactly one cycle, out_word=16'h8765, no word containing 0xA/0xB delivered.
- Reset mid-operation: reset_n low for one cycle after 2 nibbles, with out_valid=1 pending -> out_valid=0, slot=0, out_word=0; next full word 0x0F0F delivered correctly.
- Gapped input: in_valid toggling every other cycle, delivering 0xC,0xA,0xF,0xE -> out_word=16'hEFAC; out_word/out_valid stable across idle cycles while out_ready=0.
